// File: rtl/serdes_align_ctrl.sv
// Link training (serdes reset, bitslip, IDELAY tap stepping) and lock monitor for NUM_CHANNELS lanes.
// Define SERDES_ALIGN_CTRL_PRBS_EN to send and check PRBS7 in MONITOR instead of TRAINING_WORD.
module serdes_align_ctrl #(
  parameter int         DATA_WIDTH    = 8,
  parameter int         NUM_CHANNELS  = 2,
  parameter logic [7:0] TRAINING_WORD = 8'h5C,
  parameter int         RST_CYCLES    = 4,
  parameter int         SLIP_WAIT     = 3,
  parameter int         MATCH_CYCLES  = 16,
  parameter int         NUM_TAPS      = 32
) (
  input  logic                                 CLKDIV,
  input  logic                                 RST,
  input  logic                                 START,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   RX_DATA,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   TX_DATA,
  output logic                                 SERDES_RST,
  output logic [NUM_CHANNELS-1:0]              BITSLIP,
  output logic [NUM_CHANNELS-1:0]              IDELAY_CE,
  output logic                                 IDELAY_INC,
  output logic [NUM_CHANNELS-1:0]              LOCKED,
  output logic                                 BUSY,
  output logic                                 DONE,
  output logic                                 FAIL,
  output logic [15:0]                          ERR_COUNT
);
  localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TAP_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int SLIP_W  = $clog2(DATA_WIDTH);
  localparam int MATCH_W = $clog2(MATCH_CYCLES + 1);
  localparam int WAIT_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] TRAIN = TRAINING_WORD[DATA_WIDTH-1:0];

  typedef enum logic [2:0] {
    S_RST_HOLD, S_IDLE, S_SETTLE, S_CHECK, S_NEXT, S_MONITOR
  } state_t;

  state_t                  state;
  logic [3:0]              rst_cnt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [MATCH_W-1:0]      match_cnt;
  logic [SLIP_W-1:0]       slip_cnt;
  logic [TAP_W-1:0]        tap_cnt;
  logic [CH_W-1:0]         ch_idx;
  logic [NUM_CHANNELS-1:0] failed;
  logic                    restart;

  logic [DATA_WIDTH-1:0]   rx_word;
  logic [DATA_WIDTH-1:0]   exp_word [NUM_CHANNELS];
  logic                    chk_valid;
  logic [3:0]              n_err;
  logic [16:0]             err_sum;

  assign IDELAY_INC = 1'b1;

  always_comb begin
    rx_word = RX_DATA[ch_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    n_err = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (LOCKED[c] && chk_valid && (RX_DATA[c*DATA_WIDTH +: DATA_WIDTH] != exp_word[c]))
        n_err = n_err + 4'd1;
    end
    err_sum = {1'b0, ERR_COUNT} + {13'd0, n_err};
  end

`ifdef SERDES_ALIGN_CTRL_PRBS_EN
  // PRBS7 (x^7+x^6+1): the word is the next DATA_WIDTH generator bits, MSB first.
  function automatic logic [DATA_WIDTH-1:0] prbs_word(input logic [6:0] s);
    logic [6:0]            st;
    logic [DATA_WIDTH-1:0] w;
    logic                  b;
    st = s;
    w  = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      b = st[6] ^ st[5];
      w[DATA_WIDTH-1-i] = b;
      st = {st[5:0], b};
    end
    return w;
  endfunction

  function automatic logic [6:0] prbs_adv(input logic [6:0] s, input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH+6:0] t;
    t = {s, w};
    return t[6:0];
  endfunction

  logic [6:0] tx_lfsr;
  logic [6:0] chk_lfsr [NUM_CHANNELS];
  logic [3:0] sync_cnt;

  assign chk_valid = (sync_cnt == 4'd8);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++)
      exp_word[c] = prbs_word(chk_lfsr[c]);
  end

  // Checker state is loaded from the received stream for 8 words, then free-runs on its own prediction.
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      TX_DATA  <= {NUM_CHANNELS{TRAIN}};
      tx_lfsr  <= 7'h7F;
      sync_cnt <= '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) chk_lfsr[c] <= 7'h7F;
    end else if (state == S_MONITOR) begin
      TX_DATA <= {NUM_CHANNELS{prbs_word(tx_lfsr)}};
      tx_lfsr <= prbs_adv(tx_lfsr, prbs_word(tx_lfsr));
      if (sync_cnt != 4'd8) sync_cnt <= sync_cnt + 4'd1;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++)
        chk_lfsr[c] <= chk_valid ? prbs_adv(chk_lfsr[c], exp_word[c])
                                 : prbs_adv(chk_lfsr[c], RX_DATA[c*DATA_WIDTH +: DATA_WIDTH]);
    end else begin
      TX_DATA  <= {NUM_CHANNELS{TRAIN}};
      tx_lfsr  <= 7'h7F;
      sync_cnt <= '0;
    end
  end
`else
  assign TX_DATA   = {NUM_CHANNELS{TRAIN}};
  assign chk_valid = 1'b1;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++)
      exp_word[c] = TRAIN;
  end
`endif

  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      state      <= S_RST_HOLD;
      SERDES_RST <= 1'b1;
      BITSLIP    <= '0;
      IDELAY_CE  <= '0;
      LOCKED     <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      FAIL       <= 1'b0;
      ERR_COUNT  <= '0;
      rst_cnt    <= '0;
      wait_cnt   <= '0;
      match_cnt  <= '0;
      slip_cnt   <= '0;
      tap_cnt    <= '0;
      ch_idx     <= '0;
      failed     <= '0;
      restart    <= 1'b0;
    end else begin
      BITSLIP   <= '0;
      IDELAY_CE <= '0;
      case (state)
        S_RST_HOLD: begin
          if (rst_cnt == 4'(RST_CYCLES - 1)) begin
            SERDES_RST <= 1'b0;
            rst_cnt    <= '0;
            state      <= S_IDLE;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        S_IDLE: begin
          if (START || restart) begin
            restart   <= 1'b0;
            LOCKED    <= '0;
            FAIL      <= 1'b0;
            DONE      <= 1'b0;
            ERR_COUNT <= '0;
            failed    <= '0;
            BUSY      <= 1'b1;
            ch_idx    <= '0;
            tap_cnt   <= '0;
            slip_cnt  <= '0;
            wait_cnt  <= '0;
            state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
            wait_cnt  <= '0;
            match_cnt <= '0;
            state     <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (rx_word == TRAIN) begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt == MATCH_W'(MATCH_CYCLES - 1)) begin
              LOCKED[ch_idx] <= 1'b1;
              state          <= S_NEXT;
            end
          end else if (slip_cnt != SLIP_W'(DATA_WIDTH - 1)) begin
            BITSLIP[ch_idx] <= 1'b1;
            slip_cnt        <= slip_cnt + 1'b1;
            state           <= S_SETTLE;
          end else begin
            // The last-tap step is still issued so the delay line wraps back to tap 0.
            IDELAY_CE[ch_idx] <= 1'b1;
            slip_cnt          <= '0;
            if (tap_cnt == TAP_W'(NUM_TAPS - 1)) begin
              failed[ch_idx] <= 1'b1;
              state          <= S_NEXT;
            end else begin
              tap_cnt <= tap_cnt + 1'b1;
              state   <= S_SETTLE;
            end
          end
        end
        S_NEXT: begin
          tap_cnt  <= '0;
          slip_cnt <= '0;
          if (ch_idx == CH_W'(NUM_CHANNELS - 1)) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            FAIL  <= |failed;
            state <= S_MONITOR;
          end else begin
            ch_idx <= ch_idx + 1'b1;
            state  <= S_SETTLE;
          end
        end
        S_MONITOR: begin
          if (START) begin
            LOCKED     <= '0;
            FAIL       <= 1'b0;
            DONE       <= 1'b0;
            ERR_COUNT  <= '0;
            failed     <= '0;
            BUSY       <= 1'b1;
            restart    <= 1'b1;
            SERDES_RST <= 1'b1;
            rst_cnt    <= '0;
            state      <= S_RST_HOLD;
          end else begin
            ERR_COUNT <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
          end
        end
        default: state <= S_RST_HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Bench for serdes_align_ctrl: behavioural loopback (rotation, bitslip, IDELAY taps) plus expectation scoreboard.
`timescale 1ns/1ps
module tb_serdes_align_ctrl;
  localparam int         W   = 8;
  localparam int         NCH = 2;
  localparam int         SW  = 3;
  localparam logic [7:0] TW  = 8'h5C;

  logic             CLKDIV = 1'b0;
  logic             RST    = 1'b1;
  logic             START  = 1'b0;
  logic [NCH*W-1:0] rx_data;
  logic [NCH*W-1:0] tx_data;
  logic             serdes_rst, idelay_inc, busy, done, fail_flag;
  logic [NCH-1:0]   bitslip, idelay_ce, locked;
  logic [15:0]      err_count;

  serdes_align_ctrl #(
    .DATA_WIDTH(W), .NUM_CHANNELS(NCH), .TRAINING_WORD(TW), .RST_CYCLES(4),
    .SLIP_WAIT(SW), .MATCH_CYCLES(16), .NUM_TAPS(32)
  ) dut (
    .CLKDIV(CLKDIV), .RST(RST), .START(START), .RX_DATA(rx_data), .TX_DATA(tx_data),
    .SERDES_RST(serdes_rst), .BITSLIP(bitslip), .IDELAY_CE(idelay_ce), .IDELAY_INC(idelay_inc),
    .LOCKED(locked), .BUSY(busy), .DONE(done), .FAIL(fail_flag), .ERR_COUNT(err_count)
  );

  always #5 CLKDIV = ~CLKDIV;

  // Loopback configuration (written by the stimulus process only)
  int unsigned    rot [NCH];
  int unsigned    good_tap [NCH];
  logic           tie_en [NCH];
  logic [W-1:0]   tie_val [NCH];
  logic [W-1:0]   flip [NCH];
  // Loopback state and pulse statistics (written by the monitor process only)
  int unsigned    slips [NCH];
  int unsigned    taps [NCH];
  int unsigned    n_bs [NCH];
  int unsigned    n_ce [NCH];
  int unsigned    since_ce [NCH];
  int unsigned    bad_ce [NCH];
  int unsigned    rule_viol = 0;
  int unsigned    gap = 100;

  int unsigned    b_bs [NCH];
  int unsigned    b_ce [NCH];
  int unsigned    b_bad [NCH];

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned k);
    logic [2*W-1:0] d;
    d = {x, x};
    d = d >> (W - k);
    return d[W-1:0];
  endfunction

  always_comb begin
    rx_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (tie_en[c])
        rx_data[c*W +: W] = tie_val[c];
      else if (taps[c] < good_tap[c])
        rx_data[c*W +: W] = '0;
      else
        rx_data[c*W +: W] = rotl(tx_data[c*W +: W], (rot[c] + W - (slips[c] % W)) % W) ^ flip[c];
    end
  end

  initial begin
    for (int c = 0; c < NCH; c++) begin
      slips[c] = 0; taps[c] = 0; n_bs[c] = 0; n_ce[c] = 0; since_ce[c] = 0; bad_ce[c] = 0;
    end
  end

  always @(negedge CLKDIV) begin
    for (int c = 0; c < NCH; c++) begin
      if (serdes_rst) begin
        slips[c] = 0; taps[c] = 0; since_ce[c] = 0;
      end
      if (bitslip[c]) begin
        n_bs[c]++; slips[c]++; since_ce[c]++;
      end
      if (idelay_ce[c]) begin
        n_ce[c]++; taps[c]++;
        if (since_ce[c] != W - 1) bad_ce[c]++;
        since_ce[c] = 0;
      end
      if (bitslip[c] && idelay_ce[c]) rule_viol++;
    end
    if ($countones(bitslip | idelay_ce) > 1) rule_viol++;
    if (|(bitslip | idelay_ce)) begin
      if (gap < SW) rule_viol++;
      gap = 0;
    end else if (gap < 100) begin
      gap++;
    end
  end

  // Scoreboard
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic score(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: no expectation queued, got %0h", got);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(negedge CLKDIV);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic count_srst(output int unsigned n);
    n = 0;
    while (serdes_rst && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic snap();
    for (int c = 0; c < NCH; c++) begin
      b_bs[c] = n_bs[c]; b_ce[c] = n_ce[c]; b_bad[c] = bad_ce[c];
    end
  endtask

  int unsigned n_srst;
  int unsigned n_wait;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      rot[c] = 0; good_tap[c] = 0; tie_en[c] = 1'b0; tie_val[c] = '0; flip[c] = '0;
    end
    tick(); tick();

    // Reset values
    expect_val("rst_serdes_rst", 1);
    expect_val("rst_pulses", 0);
    expect_val("rst_locked", 0);
    expect_val("rst_busy_done_fail", 0);
    expect_val("rst_err_count", 0);
    expect_val("rst_tx_data", 32'h5C5C);
    expect_val("rst_idelay_inc", 1);
    score(serdes_rst);
    score({bitslip, idelay_ce});
    score(locked);
    score({busy, done, fail_flag});
    score(err_count);
    score(tx_data);
    score(idelay_inc);

    expect_val("srst_cycles_powerup", 4);
    RST = 1'b0;
    count_srst(n_srst);
    score(n_srst);
    tick(); tick();

    // Lock on first tap: ch0 rotated by 3, ch1 aligned
    rot[0] = 3; rot[1] = 0;
    snap();
    expect_val("a_busy", 1);
    expect_val("a_done", 1);
    expect_val("a_locked", 2'b11);
    expect_val("a_fail_flag", 0);
    expect_val("a_busy_after", 0);
    expect_val("a_bitslip0", 3);
    expect_val("a_bitslip1", 0);
    expect_val("a_idelay_ce", 0);
    pulse_start();
    score(busy);
    wait_done(5000);
    score(done);
    score(locked);
    score(fail_flag);
    score(busy);
    score(n_bs[0] - b_bs[0]);
    score(n_bs[1] - b_bs[1]);
    score((n_ce[0] - b_ce[0]) + (n_ce[1] - b_ce[1]));

    // Monitor errors: one corrupted ch0 word, then saturation with both corrupted
    repeat (20) tick();
    expect_val("err_single", 1);
    flip[0] = 8'h01;
    tick();
    flip[0] = '0;
    repeat (3) tick();
    score(err_count);
    expect_val("err_saturate", 16'hFFFF);
    expect_val("err_hold", 16'hFFFF);
    flip[0] = 8'h10; flip[1] = 8'h10;
    repeat (40000) tick();
    score(err_count);
    flip[0] = '0; flip[1] = '0;
    repeat (5) tick();
    score(err_count);

    // Lock needs taps: ch0 only visible from tap 2; 14 slips total bring rotation 6 to zero
    rot[0] = 6; good_tap[0] = 2;
    snap();
    expect_val("b_err_cleared", 0);
    expect_val("b_done_cleared", 0);
    expect_val("b_srst_cycles", 4);
    expect_val("b_done", 1);
    expect_val("b_locked", 2'b11);
    expect_val("b_fail_flag", 0);
    expect_val("b_idelay_ce0", 2);
    expect_val("b_bitslip0", 14);
    expect_val("b_slips_before_ce0", 0);
    expect_val("b_bitslip1", 0);
    pulse_start();
    score(err_count);
    score(done);
    count_srst(n_srst);
    score(n_srst);
    wait_done(5000);
    score(done);
    score(locked);
    score(fail_flag);
    score(n_ce[0] - b_ce[0]);
    score(n_bs[0] - b_bs[0]);
    score(bad_ce[0] - b_bad[0]);
    score(n_bs[1] - b_bs[1]);

    // Never matches: ch1 tied to 0
    repeat (10) tick();
    rot[0] = 0; good_tap[0] = 0;
    tie_en[1] = 1'b1; tie_val[1] = 8'h00;
    snap();
    expect_val("c_done", 1);
    expect_val("c_fail_flag", 1);
    expect_val("c_locked", 2'b01);
    expect_val("c_idelay_ce1", 32);
    expect_val("c_bitslip1", 224);
    expect_val("c_slips_before_ce1", 0);
    expect_val("c_idelay_ce1_later", 32);
    pulse_start();
    wait_done(20000);
    score(done);
    score(fail_flag);
    score(locked);
    score(n_ce[1] - b_ce[1]);
    score(n_bs[1] - b_bs[1]);
    score(bad_ce[1] - b_bad[1]);
    repeat (50) tick();
    score(n_ce[1] - b_ce[1]);

    // Mid-training reset during a BITSLIP pulse
    tie_en[1] = 1'b0;
    rot[0] = 5;
    expect_val("d_bitslip_seen", 1);
    expect_val("d_bitslip_drop", 0);
    expect_val("d_serdes_rst", 1);
    expect_val("d_locked", 0);
    expect_val("d_busy", 0);
    expect_val("d_srst_cycles", 4);
    pulse_start();
    n_wait = 0;
    while (!bitslip[0] && n_wait < 2000) begin
      tick();
      n_wait++;
    end
    score(bitslip[0]);
    RST = 1'b1;
    #1;
    score(bitslip);
    score(serdes_rst);
    score(locked);
    score(busy);
    tick();
    RST = 1'b0;
    count_srst(n_srst);
    score(n_srst);
    tick();
    snap();
    expect_val("d_retrain_done", 1);
    expect_val("d_retrain_locked", 2'b11);
    expect_val("d_retrain_fail_flag", 0);
    expect_val("d_retrain_bitslip0", 5);
    pulse_start();
    wait_done(5000);
    score(done);
    score(locked);
    score(fail_flag);
    score(n_bs[0] - b_bs[0]);

    // Clean loopback for 1000 cycles, then one flipped bit on ch1
    expect_val("clean_err", 0);
    expect_val("flip_err", 1);
    repeat (1000) tick();
    score(err_count);
    flip[1] = 8'h04;
    tick();
    flip[1] = '0;
    repeat (3) tick();
    score(err_count);

    expect_val("pulse_rules", 0);
    score(rule_viol);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
